// File: rtl/onehot_sender_mc_pkg.sv
// Shared defaults and helpers for the multi-channel one-hot sender.
// The default-size macros live here so that every file compiled after the
// package (interface, arbiter, top) sees the same channel/counter/gap values.

`ifndef ONEHOT_SENDER_MC_DEFINES
`define ONEHOT_SENDER_MC_DEFINES
`define ONEHOT_CH        4
`define ONEHOT_CNT_BITS  3
`define ONEHOT_GAP       0
// Width needed to index n items, never less than one bit.
`define ONEHOT_LOG2(n)   (((n) > 1) ? $clog2(n) : 1)
`endif

package onehot_sender_mc_pkg;

    // What a per-channel pending counter does on a given cycle.
    typedef enum logic [1:0] {
        PEND_HOLD = 2'd0,
        PEND_INC  = 2'd1,
        PEND_DEC  = 2'd2,
        PEND_DROP = 2'd3
    } pend_op_e;

    // Request and grant in the same cycle cancel out, so a full counter that
    // is also being served never drops the incoming request.
    function automatic pend_op_e pend_op(input logic inc, input logic dec, input logic at_max);
        pend_op_e op;
        op = PEND_HOLD;
        if (inc && !dec) begin
            op = at_max ? PEND_DROP : PEND_INC;
        end else if (!inc && dec) begin
            op = PEND_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/onehot_sender_mc_if.sv
// Request/pulse bus between event producers and the one-hot sender.
// master = producer/consumer side, slave = the sender itself.

interface onehot_sender_mc_if #(
    parameter int CH = `ONEHOT_CH
);
    logic [CH-1:0] in;
    logic          out_ready;
    logic          ovf_clr;
    logic [CH-1:0] out;
    logic [CH-1:0] ovf;
    logic          busy;

    modport master (
        output in,
        output out_ready,
        output ovf_clr,
        input  out,
        input  ovf,
        input  busy
    );

    modport slave (
        input  in,
        input  out_ready,
        input  ovf_clr,
        output out,
        output ovf,
        output busy
    );
endinterface

// File: rtl/onehot_sender_mc_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// winner and wraps, so every requesting channel is reached within CH grants.

module onehot_rr_arbiter #(
    parameter int CH    = `ONEHOT_CH,
    parameter int PTR_W = `ONEHOT_LOG2(CH)
) (
    input  logic [CH-1:0]    req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [CH-1:0]    grant_o,
    output logic [PTR_W-1:0] winner_o,
    output logic             valid_o
);

    logic [PTR_W-1:0] idx;

    // Walk channels ptr+1 .. ptr+CH (mod CH); the first requester wins.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int k = 1; k <= CH; k++) begin
            idx = PTR_W'((int'(ptr_i) + k) % CH);
            if (!valid_o && req_i[idx]) begin
                valid_o      = 1'b1;
                grant_o[idx] = 1'b1;
                winner_o     = idx;
            end
        end
    end

endmodule

// File: rtl/onehot_sender_mc.sv
// Multi-channel one-hot pulse sender. Requests are queued as saturating
// per-channel counts and drained as single-cycle one-hot pulses, one per
// grant, in round-robin order, gated by out_ready and an idle gap.

module onehot_sender_mc
    import onehot_sender_mc_pkg::*;
#(
    parameter int CH       = `ONEHOT_CH,
    parameter int CNT_BITS = `ONEHOT_CNT_BITS,
    parameter int GAP      = `ONEHOT_GAP
) (
    input  logic               clk,
    input  logic               rst,
    onehot_sender_mc_if.slave  bus
);

    localparam int PTR_W = `ONEHOT_LOG2(CH);
    localparam int GAP_W = `ONEHOT_LOG2(GAP + 1);

    localparam logic [CNT_BITS-1:0] PEND_MAX = '1;
    localparam logic [GAP_W-1:0]    GAP_LOAD = GAP_W'(GAP);
    // Reset pointer to the last channel so channel 0 is searched first.
    localparam logic [PTR_W-1:0]    PTR_INIT = PTR_W'(CH - 1);

    logic [CH-1:0]    req_vec;
    logic [CH-1:0]    drop_vec;
    logic [CH-1:0]    grant_vec;
    logic [PTR_W-1:0] winner;
    logic             arb_valid;
    logic             grant_en;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CH-1:0]    out_q, out_d;
    logic [CH-1:0]    ovf_q, ovf_d;

    onehot_rr_arbiter #(
        .CH    (CH),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i    (req_vec),
        .ptr_i    (ptr_q),
        .grant_o  (grant_vec),
        .winner_o (winner),
        .valid_o  (arb_valid)
    );

    // A grant sees only counts registered at the start of the cycle.
    assign grant_en = bus.out_ready && (gap_q == '0) && arb_valid;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_BITS-1:0] pend_q, pend_d;
        pend_op_e            op;

        assign op          = pend_op(bus.in[i], grant_en && grant_vec[i], pend_q == PEND_MAX);
        assign req_vec[i]  = (pend_q != '0);
        assign drop_vec[i] = (op == PEND_DROP);

        // Pending count update: saturates at PEND_MAX, never wraps.
        always_comb begin
            pend_d = pend_q;
            case (op)
                PEND_INC: pend_d = pend_q + CNT_BITS'(1);
                PEND_DEC: pend_d = pend_q - CNT_BITS'(1);
                default:  pend_d = pend_q;
            endcase
        end

        // Pending count register.
        always_ff @(posedge clk) begin
            if (rst) begin
                pend_q <= '0;
            end else begin
                pend_q <= pend_d;
            end
        end
    end

    // Pointer, gap, pulse and overflow next-state; a fresh overflow beats ovf_clr.
    always_comb begin
        ptr_d = ptr_q;
        gap_d = gap_q;
        out_d = '0;
        ovf_d = (ovf_q & ~{CH{bus.ovf_clr}}) | drop_vec;
        if (grant_en) begin
            ptr_d = winner;
            out_d = grant_vec;
        end
        if (GAP == 0) begin
            gap_d = '0;
        end else if (grant_en) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end
    end

    // Shared control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_INIT;
            gap_q <= '0;
            out_q <= '0;
            ovf_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            gap_q <= gap_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (|req_vec) | (|out_q);

endmodule

// File: tb/tb_onehot_sender_mc.sv
// Directed bench for onehot_sender_mc. Three instances share clock and reset:
// A (CNT_BITS=3, GAP=0), B (CNT_BITS=3, GAP=2), C (CNT_BITS=2, GAP=0).

module tb_onehot_sender_mc;

    logic clk = 1'b0;
    logic rst;

    int passes = 0;
    int total  = 0;

    // random-phase scoreboard for instance A
    int       pend_m [4];
    logic [3:0] ovf_m;
    int       req_cnt, pulse_cnt, drop_cnt, bad_cnt;
    logic [3:0] rin;
    logic     rrdy;
    int       guard;

    onehot_sender_mc_if #(.CH(4)) ifa ();
    onehot_sender_mc_if #(.CH(4)) ifb ();
    onehot_sender_mc_if #(.CH(4)) ifc ();

    onehot_sender_mc #(.CH(4), .CNT_BITS(3), .GAP(0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    onehot_sender_mc #(.CH(4), .CNT_BITS(3), .GAP(2)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    onehot_sender_mc #(.CH(4), .CNT_BITS(2), .GAP(0)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fold one edge of instance A into the scoreboard.
    task automatic model_step(input logic [3:0] ain, input logic ardy);
        logic [3:0] o;
        o = ifa.out;
        if (o != 4'd0 && !ardy) bad_cnt++;
        if ((o & (o - 4'd1)) != 4'd0) bad_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (o[i] && pend_m[i] == 0) bad_cnt++;
            req_cnt   += int'(ain[i]);
            pulse_cnt += int'(o[i]);
            if (ain[i] && !o[i]) begin
                if (pend_m[i] == 7) begin
                    drop_cnt++;
                    ovf_m[i] = 1'b1;
                end else begin
                    pend_m[i]++;
                end
            end else if (!ain[i] && o[i]) begin
                pend_m[i]--;
            end
        end
    endtask

    initial begin
        // ---------------- reset with all requests high ----------------
        rst = 1'b1;
        ifa.in = 4'hF; ifa.out_ready = 1'b1; ifa.ovf_clr = 1'b0;
        ifb.in = 4'hF; ifb.out_ready = 1'b1; ifb.ovf_clr = 1'b0;
        ifc.in = 4'hF; ifc.out_ready = 1'b1; ifc.ovf_clr = 1'b0;
        for (int r = 0; r < 4; r++) begin
            tick();
            chk("rst_out_a", ifa.out, 4'h0);
            chk("rst_ovf_a", ifa.ovf, 4'h0);
            chk("rst_busy_a", ifa.busy, 1'b0);
            chk("rst_busy_c", ifc.busy, 1'b0);
        end
        rst = 1'b0;
        ifa.in = 4'h0; ifb.in = 4'h0; ifc.in = 4'h0;
        tick();
        chk("post_rst_busy_a", ifa.busy, 1'b0);
        chk("post_rst_busy_b", ifb.busy, 1'b0);
        chk("post_rst_out_b", ifb.out, 4'h0);

        // ---------------- round robin burst on A ----------------
        ifa.in = 4'hF; tick();
        chk("rr_lat", ifa.out, 4'h0);
        ifa.in = 4'h0;
        tick(); chk("rr0", ifa.out, 4'b0001);
        tick(); chk("rr1", ifa.out, 4'b0010);
        tick(); chk("rr2", ifa.out, 4'b0100);
        tick(); chk("rr3", ifa.out, 4'b1000);
        tick(); chk("rr_idle", ifa.out, 4'h0);
        chk("rr_busy", ifa.busy, 1'b0);
        // last winner was 3: second burst {0,1,3} wraps to 0 first
        ifa.in = 4'b1011; tick(); ifa.in = 4'h0;
        tick(); chk("rr2_0", ifa.out, 4'b0001);
        tick(); chk("rr2_1", ifa.out, 4'b0010);
        tick(); chk("rr2_2", ifa.out, 4'b1000);
        tick(); chk("rr2_idle", ifa.out, 4'h0);

        // ---------------- single request, 2-clock latency ----------------
        ifa.in = 4'b0100; tick();
        chk("single_k", ifa.out, 4'h0);
        chk("single_busy", ifa.busy, 1'b1);
        ifa.in = 4'h0; tick();
        chk("single_k1", ifa.out, 4'b0100);
        tick();
        chk("single_end", ifa.out, 4'h0);
        chk("single_idle", ifa.busy, 1'b0);

        // ---------------- simultaneous inc/dec at MAX on A ----------------
        ifa.out_ready = 1'b0; ifa.in = 4'b0001;
        for (int r = 0; r < 7; r++) tick();
        chk("fill_out", ifa.out, 4'h0);
        chk("fill_ovf", ifa.ovf, 4'h0);
        ifa.out_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            tick();
            chk("incdec_out", ifa.out, 4'b0001);
        end
        chk("incdec_ovf", ifa.ovf, 4'h0);
        ifa.in = 4'h0;
        for (int r = 0; r < 7; r++) begin
            tick();
            chk("incdec_drain", ifa.out, 4'b0001);
        end
        tick();
        chk("incdec_done", ifa.out, 4'h0);
        chk("incdec_busy", ifa.busy, 1'b0);

        // ---------------- GAP=2 spacing on B ----------------
        ifb.in = 4'b0010;
        tick(); chk("gap_e1", ifb.out, 4'h0);
        tick(); chk("gap_e2", ifb.out, 4'b0010);
        tick(); chk("gap_e3", ifb.out, 4'h0);
        ifb.in = 4'h0;
        tick(); chk("gap_e4", ifb.out, 4'h0);
        tick(); chk("gap_e5", ifb.out, 4'b0010);
        tick(); chk("gap_e6", ifb.out, 4'h0);
        tick(); chk("gap_e7", ifb.out, 4'h0);
        tick(); chk("gap_e8", ifb.out, 4'b0010);
        tick(); chk("gap_e9", ifb.out, 4'h0);
        chk("gap_busy", ifb.busy, 1'b0);

        // ---------------- ready drop on B ----------------
        ifb.in = 4'b0010; tick();
        ifb.in = 4'h0; ifb.out_ready = 1'b0;
        tick(); chk("rdy_hold0", ifb.out, 4'h0);
        tick(); chk("rdy_hold1", ifb.out, 4'h0);
        chk("rdy_busy", ifb.busy, 1'b1);
        ifb.out_ready = 1'b1;
        tick(); chk("rdy_pulse", ifb.out, 4'b0010);
        tick(); chk("rdy_nodup0", ifb.out, 4'h0);
        tick(); chk("rdy_nodup1", ifb.out, 4'h0);
        chk("rdy_idle", ifb.busy, 1'b0);

        // ---------------- saturation on C (MAX=3) ----------------
        ifc.out_ready = 1'b0; ifc.in = 4'b1000;
        for (int r = 0; r < 3; r++) tick();
        chk("sat_no_ovf", ifc.ovf, 4'h0);
        tick(); tick();
        chk("sat_ovf", ifc.ovf, 4'b1000);
        chk("sat_out", ifc.out, 4'h0);
        ifc.in = 4'h0; ifc.out_ready = 1'b1;
        tick(); chk("sat_p0", ifc.out, 4'b1000);
        tick(); chk("sat_p1", ifc.out, 4'b1000);
        tick(); chk("sat_p2", ifc.out, 4'b1000);
        tick(); chk("sat_p3", ifc.out, 4'h0);
        chk("sat_ovf_sticky", ifc.ovf, 4'b1000);
        ifc.ovf_clr = 1'b1; tick(); ifc.ovf_clr = 1'b0;
        chk("sat_clr", ifc.ovf, 4'h0);
        ifc.out_ready = 1'b0; ifc.in = 4'b1000;
        for (int r = 0; r < 3; r++) tick();
        ifc.ovf_clr = 1'b1; tick();
        chk("sat_clr_vs_ovf", ifc.ovf, 4'b1000);
        ifc.ovf_clr = 1'b0; ifc.in = 4'h0; ifc.out_ready = 1'b1;
        tick(); chk("sat2_p0", ifc.out, 4'b1000);
        tick(); chk("sat2_p1", ifc.out, 4'b1000);
        tick(); chk("sat2_p2", ifc.out, 4'b1000);
        tick(); chk("sat2_p3", ifc.out, 4'h0);
        chk("sat2_busy", ifc.busy, 1'b0);

        // ---------------- randomised traffic on A ----------------
        for (int i = 0; i < 4; i++) pend_m[i] = 0;
        ovf_m = 4'h0;
        req_cnt = 0; pulse_cnt = 0; drop_cnt = 0; bad_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            rin  = 4'($urandom);
            rrdy = ($urandom_range(0, 3) != 0);
            ifa.in = rin; ifa.out_ready = rrdy;
            tick();
            model_step(rin, rrdy);
        end
        ifa.in = 4'h0; ifa.out_ready = 1'b1;
        guard = 0;
        while (ifa.busy && guard < 100) begin
            tick();
            model_step(4'h0, 1'b1);
            guard++;
        end
        chk("rand_drained", ifa.busy, 1'b0);
        chk("rand_bad", 32'(bad_cnt), 32'd0);
        chk("rand_conserve", 32'(pulse_cnt + drop_cnt), 32'(req_cnt));
        chk("rand_ovf", ifa.ovf, ovf_m);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/onehot_sender_mc.md
# onehot_sender_mc

Multi-channel one-hot pulse sender: the parametrised successor of the single-channel one-hot sender. Accepts up to CH independent request strobes per cycle, queues them as per-channel pending counts, and emits them as a one-hot pulse vector, at most one bit per cycle. Channels are served in round-robin order, gated by a downstream ready and an optional minimum idle gap between pulses. It sits between event producers (counters, FIFO status, random-valid sources) and a consumer that accepts one event per cycle.

## Interface

Parameters:
- CH, 4: number of channels, ≥2.
- CNT_BITS, 3: pending-counter width; MAX = 2^CNT_BITS−1 requests held per channel.
- GAP, 0: idle cycles forced after each emitted pulse; 0 allows back-to-back pulses.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  CH  request strobes; each bit high for one cycle = one request on that channel.
- out_ready  in  1  consumer can take a pulse this cycle.
- ovf_clr  in  1  clears all sticky overflow flags.
- out  out  CH  registered one-hot pulse; all-zero or exactly one bit set.
- ovf  out  CH  sticky per-channel overflow (request dropped).
- busy  out  1  any pending count nonzero or out nonzero.

## Operation

- Per channel i, the state is pend[i] (CNT_BITS). Each cycle:
  - inc = in[i]; dec = channel i granted this cycle.
  - inc & !dec: if pend[i] < MAX then +1; else the request is dropped and ovf[i] ← 1.
  - !inc & dec: −1. inc & dec: unchanged, no overflow even at MAX.
- Grant decision, combinational in cycle t: eligible when out_ready=1, gap_cnt=0 and some pend[i]>0. Uses pend values registered at the start of cycle t; a same-cycle in[i] is not visible.
- Round robin: search starts at ptr+1 mod CH, wrapping; first channel with pend>0 wins; ptr ← winner on grant. ptr holds when there is no grant.
- out ← onehot(winner) on a grant, else 0. Each pulse lasts exactly one cycle.
- gap_cnt ← GAP on a grant; otherwise it decrements while nonzero. GAP=0 means gap_cnt is always 0.
- ovf_clr clears ovf; a new overflow in the same cycle wins, so that bit stays 1.
- busy = |pend nonzero | |out.

## Timing

- Reset (synchronous): pend=0, ovf=0, out=0, gap_cnt=0, ptr=CH−1 so channel 0 is first served; busy=0 the cycle after rst is sampled.
- Latency: in[i] sampled at edge k → pend updated after k → grant in cycle k+1 → out[i] high for the cycle after edge k+1. Minimum in→out latency is 2 clocks.
- Throughput: 1 pulse per (GAP+1) cycles across all channels.
- out_ready=0: no grant, and out is 0 the next cycle. Pending counts still accept increments. gap_cnt keeps counting down.
- A mid-operation reset discards all pending requests. No pulse appears on out in the cycle after rst is sampled.
- Counts never wrap. Saturation at MAX is the only loss mechanism, and it is always flagged.

## Structure

- Shared define file: default macros ONEHOT_CH, ONEHOT_CNT_BITS, ONEHOT_GAP, and a log2 macro for the ptr width.
- Sub-module onehot_rr_arbiter (parameter CH): inputs req[CH] and ptr, outputs a one-hot grant and the winner index. Purely combinational. Instantiated once.
- Top: generate loop of per-channel pend counters, plus the ptr, gap_cnt and out registers.

## Test plan

- Reset: rst high 4 cycles with in=4'b1111 → out=0, ovf=0, busy=0 throughout; after release, all counters are 0.
- Single request: CH=4, GAP=0, ready=1; in=4'b0100 for one cycle at edge k → out=4'b0100 for exactly one cycle after edge k+1, then busy=0.
- Round robin: in=4'b1111 for one cycle → out sequence 0001, 0010, 0100, 1000 on consecutive cycles. A second burst is served starting after the last winner.
- Gap and ready: GAP=2, 3 requests on channel 1 → pulses spaced 3 cycles apart. Dropping ready for 2 cycles delays the pending pulse, with no loss and no duplicate.
- Saturation: CNT_BITS=2, ready=0, 5 requests on channel 3 → pend=3 and ovf[3]=1. Raising ready yields exactly 3 pulses. ovf_clr clears the flag; ovf_clr asserted in the same cycle as another overflow leaves ovf[3]=1.
- Simultaneous inc/dec: channel 0 at MAX with in[0]=1 every cycle and ready=1 → continuous pulses on out[0] with GAP=0, and ovf[0] stays 0. Randomised in/ready for 400 cycles → total pulses + dropped requests = total requests, and out is always one-hot or zero.
